rvvi_trace_gen: RTL

- Producer side of the RVVI trace interface: accepts in-order retirement records from the core pipeline, holds each until its register writeback is complete, and drives a single-hart, single-retire RVVI trace stream.
- Its output is consumed each clock by the coverage collector and the lockstep checker.
- Retirement records may carry their writeback data immediately or receive it later by tag (long-latency ops such as divide or loads).

---
 rtl/rvvi_trace_gen.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rvvi_trace_gen.sv
// rvvi_trace_gen: in-order retirement buffer driving a single-hart, single-retire
// RVVI trace; each record is held until its register writeback has completed.
module rvvi_trace_gen #(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAGW  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ret_valid,
    output logic            ret_ready,
    output logic [TAGW-1:0] ret_tag,
    input  logic [XLEN-1:0] ret_pc,
    input  logic [ILEN-1:0] ret_insn,
    input  logic            ret_trap,
    input  logic [4:0]      ret_rd,
    input  logic            ret_rd_we,
    input  logic            ret_wb_now,
    input  logic [XLEN-1:0] ret_wb_data,
    input  logic            wb_valid,
    input  logic [TAGW-1:0] wb_tag,
    input  logic [XLEN-1:0] wb_data,
    output logic            rvvi_valid,
    output logic [63:0]     rvvi_order,
    output logic [ILEN-1:0] rvvi_insn,
    output logic [XLEN-1:0] rvvi_pc_rdata,
    output logic            rvvi_trap,
    output logic [31:0]     rvvi_x_wb,
    output logic [XLEN-1:0] rvvi_x_wdata,
    output logic            wb_err
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
        logic            trap;
        logic [4:0]      rd;
        logic            rd_we;
        logic [XLEN-1:0] data;
    } slot_t;

    slot_t [DEPTH-1:0] slot_q, slot_d;
    logic [DEPTH-1:0]  vld_q, vld_d, cmpl_q, cmpl_d;
    logic [TAGW:0]     wr_q, wr_d, rd_q, rd_d;
    logic [63:0]       order_q, order_d;
    logic              out_vld_q, out_vld_d, trap_q, trap_d, err_q, err_d;
    logic [ILEN-1:0]   insn_q, insn_d;
    logic [XLEN-1:0]   pc_q, pc_d, wdata_q, wdata_d;
    logic [31:0]       xwb_q, xwb_d, mask;
    logic [TAGW-1:0]   head, wr_idx;
    logic              full, push, pop;

    always_comb begin
        head   = rd_q[TAGW-1:0];
        wr_idx = wr_q[TAGW-1:0];
        full   = (wr_q[TAGW] != rd_q[TAGW]) && (wr_idx == head);
        push   = ret_valid && !full;
        pop    = vld_q[head] && cmpl_q[head];
        mask   = (slot_q[head].rd_we && !slot_q[head].trap && slot_q[head].rd != 5'd0)
                 ? 32'd1 << slot_q[head].rd : 32'd0;
        slot_d    = slot_q;
        vld_d     = vld_q;
        cmpl_d    = cmpl_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        order_d   = order_q;
        err_d     = err_q;
        out_vld_d = 1'b0;
        insn_d    = '0;
        pc_d      = '0;
        trap_d    = 1'b0;
        xwb_d     = '0;
        wdata_d   = '0;
        if (push) begin
            slot_d[wr_idx] = '{ret_pc, ret_insn, ret_trap, ret_rd, ret_rd_we, ret_wb_data};
            vld_d[wr_idx]  = 1'b1;
            cmpl_d[wr_idx] = ret_trap || !ret_rd_we || ret_rd == 5'd0 || ret_wb_now;
            wr_d           = wr_q + 1'b1;
        end
        // Only slots valid before this edge accept a writeback, so a same-cycle push is never hit.
        if (wb_valid) begin
            if (vld_q[wb_tag] && !cmpl_q[wb_tag]) begin
                slot_d[wb_tag].data = wb_data;
                cmpl_d[wb_tag]      = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        if (pop) begin
            vld_d[head]  = 1'b0;
            cmpl_d[head] = 1'b0;
            rd_d         = rd_q + 1'b1;
            order_d      = order_q + 64'd1;
            out_vld_d    = 1'b1;
            insn_d       = slot_q[head].insn;
            pc_d         = slot_q[head].pc;
            trap_d       = slot_q[head].trap;
            xwb_d        = mask;
            wdata_d      = (mask != 32'd0) ? slot_q[head].data : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q    <= '0;
            vld_q     <= '0;
            cmpl_q    <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            order_q   <= '0;
            err_q     <= 1'b0;
            out_vld_q <= 1'b0;
            insn_q    <= '0;
            pc_q      <= '0;
            trap_q    <= 1'b0;
            xwb_q     <= '0;
            wdata_q   <= '0;
        end else begin
            slot_q    <= slot_d;
            vld_q     <= vld_d;
            cmpl_q    <= cmpl_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            order_q   <= order_d;
            err_q     <= err_d;
            out_vld_q <= out_vld_d;
            insn_q    <= insn_d;
            pc_q      <= pc_d;
            trap_q    <= trap_d;
            xwb_q     <= xwb_d;
            wdata_q   <= wdata_d;
        end
    end

    assign ret_ready     = !full;
    assign ret_tag       = wr_idx;
    assign rvvi_valid    = out_vld_q;
    assign rvvi_order    = order_q;
    assign rvvi_insn     = insn_q;
    assign rvvi_pc_rdata = pc_q;
    assign rvvi_trap     = trap_q;
    assign rvvi_x_wb     = xwb_q;
    assign rvvi_x_wdata  = wdata_q;
    assign wb_err        = err_q;
endmodule
